// File: rtl/control_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : control_pipe
//  Description : RV32I main-control decode with ID/EX, EX/MEM and MEM/WB
//                control registers, load-use interlock, redirect squash,
//                illegal-opcode flag and x0 write suppression.
//  Revision    : 1.0  initial release
// ============================================================================
module control_pipe #(
   parameter int RA_W     = 5,
   parameter bit STALL_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid_i,
   input  logic [6:0]      id_opcode_i,
   input  logic [RA_W-1:0] id_rs1_i,
   input  logic [RA_W-1:0] id_rs2_i,
   input  logic [RA_W-1:0] id_rd_i,
   input  logic            ex_redirect_i,
   output logic            id_illegal_o,
   output logic            stall_o,
   output logic            ex_valid_o,
   output logic            ex_branch_o,
   output logic            ex_jump_o,
   output logic            ex_jalr_o,
   output logic [1:0]      ex_ula_op_o,
   output logic [1:0]      ex_alu_src1_o,
   output logic [1:0]      ex_alu_src2_o,
   output logic [RA_W-1:0] ex_rd_o,
   output logic            mem_valid_o,
   output logic            mem_rd_o,
   output logic            mem_wr_o,
   output logic            wb_valid_o,
   output logic            wb_reg_wr_o,
   output logic            wb_mux_reg_wr_o,
   output logic [RA_W-1:0] wb_rd_o
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   typedef struct packed {
      logic       branch;
      logic       jump;
      logic       jalr;
      logic [1:0] ula_op;
      logic [1:0] src1;
      logic [1:0] src2;
      logic       mem_rd;
      logic       mem_wr;
      logic       reg_wr;
      logic       mux_reg_wr;
   } ctrl_t;

   ctrl_t           w_dec;
   logic            w_legal;
   logic            w_use_rs1;
   logic            w_use_rs2;
   logic [RA_W-1:0] w_dec_rd;
   logic            w_hazard;
   logic            w_stall;
   logic            w_issue;

   logic            ex_valid_d;
   ctrl_t           ex_ctrl_d;
   logic [RA_W-1:0] ex_rd_d;

   logic            ex_valid_q;
   ctrl_t           ex_ctrl_q;
   logic [RA_W-1:0] ex_rd_q;
   logic            mem_valid_q;
   logic            mem_rd_q;
   logic            mem_wr_q;
   logic            mem_reg_wr_q;
   logic            mem_mux_q;
   logic [RA_W-1:0] mem_rdaddr_q;
   logic            wb_valid_q;
   logic            wb_reg_wr_q;
   logic            wb_mux_q;
   logic [RA_W-1:0] wb_rdaddr_q;

   always_comb begin
      w_dec     = '0;
      w_legal   = 1'b1;
      w_use_rs1 = 1'b0;
      w_use_rs2 = 1'b0;
      case (id_opcode_i)
         OP_R: begin
            w_dec.reg_wr = 1'b1; w_dec.ula_op = 2'b10;
            w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
         end
         OP_I: begin
            w_dec.reg_wr = 1'b1; w_dec.ula_op = 2'b10; w_dec.src2 = 2'b01;
            w_use_rs1 = 1'b1;
         end
         OP_LOAD: begin
            w_dec.mem_rd = 1'b1; w_dec.reg_wr = 1'b1;
            w_dec.mux_reg_wr = 1'b1; w_dec.src2 = 2'b01;
            w_use_rs1 = 1'b1;
         end
         OP_STORE: begin
            w_dec.mem_wr = 1'b1; w_dec.src2 = 2'b01;
            w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
         end
         OP_BR: begin
            w_dec.branch = 1'b1;
            w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
         end
         OP_LUI: begin
            w_dec.reg_wr = 1'b1; w_dec.src1 = 2'b10; w_dec.src2 = 2'b01;
         end
         OP_AUIPC: begin
            w_dec.reg_wr = 1'b1; w_dec.src1 = 2'b01; w_dec.src2 = 2'b01;
         end
         OP_JAL: begin
            w_dec.reg_wr = 1'b1; w_dec.jump = 1'b1;
            w_dec.src1 = 2'b01; w_dec.src2 = 2'b10;
         end
         OP_JALR: begin
            w_dec.reg_wr = 1'b1; w_dec.jump = 1'b1; w_dec.jalr = 1'b1;
            w_dec.src1 = 2'b01; w_dec.src2 = 2'b10;
            w_use_rs1 = 1'b1;
         end
         default: w_legal = 1'b0;
      endcase
      if (id_rd_i == '0) begin
         w_dec.reg_wr = 1'b0;
      end
      // An illegal opcode travels as a fully empty bundle, destination included.
      w_dec_rd = w_legal ? id_rd_i : '0;
   end

   assign id_illegal_o = id_valid_i & ~w_legal;

   assign w_hazard = ex_valid_q & ex_ctrl_q.mem_rd & (ex_rd_q != '0) & id_valid_i
                   & ((w_use_rs1 & (ex_rd_q == id_rs1_i)) | (w_use_rs2 & (ex_rd_q == id_rs2_i)))
                   & ~ex_redirect_i;

   generate
      if (STALL_EN) begin : g_stall
         assign w_stall = w_hazard;
      end else begin : g_no_stall
         assign w_stall = 1'b0;
      end
   endgenerate

   assign stall_o = w_stall;
   assign w_issue = id_valid_i & ~w_stall & ~ex_redirect_i;

   always_comb begin
      ex_valid_d = w_issue;
      ex_ctrl_d  = w_issue ? w_dec : '0;
      ex_rd_d    = w_issue ? w_dec_rd : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q   <= 1'b0;
         ex_ctrl_q    <= '0;
         ex_rd_q      <= '0;
         mem_valid_q  <= 1'b0;
         mem_rd_q     <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_reg_wr_q <= 1'b0;
         mem_mux_q    <= 1'b0;
         mem_rdaddr_q <= '0;
         wb_valid_q   <= 1'b0;
         wb_reg_wr_q  <= 1'b0;
         wb_mux_q     <= 1'b0;
         wb_rdaddr_q  <= '0;
      end else begin
         ex_valid_q   <= ex_valid_d;
         ex_ctrl_q    <= ex_ctrl_d;
         ex_rd_q      <= ex_rd_d;
         mem_valid_q  <= ex_valid_q;
         mem_rd_q     <= ex_ctrl_q.mem_rd;
         mem_wr_q     <= ex_ctrl_q.mem_wr;
         mem_reg_wr_q <= ex_ctrl_q.reg_wr;
         mem_mux_q    <= ex_ctrl_q.mux_reg_wr;
         mem_rdaddr_q <= ex_rd_q;
         wb_valid_q   <= mem_valid_q;
         wb_reg_wr_q  <= mem_reg_wr_q;
         wb_mux_q     <= mem_mux_q;
         wb_rdaddr_q  <= mem_rdaddr_q;
      end
   end

   assign ex_valid_o      = ex_valid_q;
   assign ex_branch_o     = ex_valid_q & ex_ctrl_q.branch;
   assign ex_jump_o       = ex_valid_q & ex_ctrl_q.jump;
   assign ex_jalr_o       = ex_valid_q & ex_ctrl_q.jalr;
   assign ex_ula_op_o     = ex_valid_q ? ex_ctrl_q.ula_op : 2'b00;
   assign ex_alu_src1_o   = ex_valid_q ? ex_ctrl_q.src1 : 2'b00;
   assign ex_alu_src2_o   = ex_valid_q ? ex_ctrl_q.src2 : 2'b00;
   assign ex_rd_o         = ex_valid_q ? ex_rd_q : '0;
   assign mem_valid_o     = mem_valid_q;
   assign mem_rd_o        = mem_valid_q & mem_rd_q;
   assign mem_wr_o        = mem_valid_q & mem_wr_q;
   assign wb_valid_o      = wb_valid_q;
   assign wb_reg_wr_o     = wb_valid_q & wb_reg_wr_q;
   assign wb_mux_reg_wr_o = wb_valid_q & wb_mux_q;
   assign wb_rd_o         = wb_valid_q ? wb_rdaddr_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_control_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_pipe
//  Description : Directed-vector bench with per-stage scoreboard queues for
//                control_pipe; a second instance has the interlock disabled.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_control_pipe;

   // Control word: {branch,jump,jalr,ula[1:0],src1[1:0],src2[1:0],mem_rd,mem_wr,reg_wr,mux}
   localparam logic [12:0] K_R     = 13'b0_0_0_10_00_00_0_0_1_0;
   localparam logic [12:0] K_R_X0  = 13'b0_0_0_10_00_00_0_0_0_0;
   localparam logic [12:0] K_I     = 13'b0_0_0_10_00_01_0_0_1_0;
   localparam logic [12:0] K_LD    = 13'b0_0_0_00_00_01_1_0_1_1;
   localparam logic [12:0] K_LD_X0 = 13'b0_0_0_00_00_01_1_0_0_1;
   localparam logic [12:0] K_ST    = 13'b0_0_0_00_00_01_0_1_0_0;
   localparam logic [12:0] K_BR    = 13'b1_0_0_00_00_00_0_0_0_0;
   localparam logic [12:0] K_LUI   = 13'b0_0_0_00_10_01_0_0_1_0;
   localparam logic [12:0] K_AUI   = 13'b0_0_0_00_01_01_0_0_1_0;
   localparam logic [12:0] K_JAL   = 13'b0_1_0_00_01_10_0_0_1_0;
   localparam logic [12:0] K_JALR  = 13'b0_1_1_00_01_10_0_0_1_0;
   localparam logic [12:0] K_NONE  = 13'b0;

   localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011;
   localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, LUI = 7'b0110111;
   localparam logic [6:0] AUI = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
   localparam logic [6:0] SYS = 7'b1110011;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid = 1'b0;
   logic [6:0] id_opcode = 7'd0;
   logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
   logic       ex_redirect = 1'b0;

   logic       id_illegal, stall, ex_valid, ex_branch, ex_jump, ex_jalr;
   logic [1:0] ex_ula_op, ex_src1, ex_src2;
   logic [4:0] ex_rd, wb_rd;
   logic       mem_valid, mem_rd, mem_wr, wb_valid, wb_reg_wr, wb_mux;

   logic       ns_illegal, ns_stall, ns_ex_valid, ns_ex_branch, ns_ex_jump, ns_ex_jalr;
   logic [1:0] ns_ula_op, ns_src1, ns_src2;
   logic [4:0] ns_ex_rd, ns_wb_rd;
   logic       ns_mem_valid, ns_mem_rd, ns_mem_wr, ns_wb_valid, ns_wb_reg_wr, ns_wb_mux;

   always #5 clk = ~clk;

   control_pipe #(.RA_W(5), .STALL_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_opcode_i(id_opcode),
      .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd), .ex_redirect_i(ex_redirect),
      .id_illegal_o(id_illegal), .stall_o(stall), .ex_valid_o(ex_valid),
      .ex_branch_o(ex_branch), .ex_jump_o(ex_jump), .ex_jalr_o(ex_jalr),
      .ex_ula_op_o(ex_ula_op), .ex_alu_src1_o(ex_src1), .ex_alu_src2_o(ex_src2),
      .ex_rd_o(ex_rd), .mem_valid_o(mem_valid), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr),
      .wb_valid_o(wb_valid), .wb_reg_wr_o(wb_reg_wr), .wb_mux_reg_wr_o(wb_mux),
      .wb_rd_o(wb_rd)
   );

   control_pipe #(.RA_W(5), .STALL_EN(1'b0)) dut_ns (
      .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_opcode_i(id_opcode),
      .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd), .ex_redirect_i(ex_redirect),
      .id_illegal_o(ns_illegal), .stall_o(ns_stall), .ex_valid_o(ns_ex_valid),
      .ex_branch_o(ns_ex_branch), .ex_jump_o(ns_ex_jump), .ex_jalr_o(ns_ex_jalr),
      .ex_ula_op_o(ns_ula_op), .ex_alu_src1_o(ns_src1), .ex_alu_src2_o(ns_src2),
      .ex_rd_o(ns_ex_rd), .mem_valid_o(ns_mem_valid), .mem_rd_o(ns_mem_rd),
      .mem_wr_o(ns_mem_wr), .wb_valid_o(ns_wb_valid), .wb_reg_wr_o(ns_wb_reg_wr),
      .wb_mux_reg_wr_o(ns_wb_mux), .wb_rd_o(ns_wb_rd)
   );

   typedef struct {
      logic rst, v;
      logic [6:0] op;
      logic [4:0] rs1, rs2, rd;
      logic redir, st, il, is;
      logic [12:0] ctrl;
      logic [4:0] erd;
   } vec_t;

   typedef struct packed {
      logic [12:0] ctrl;
      logic [4:0]  rd;
   } exp_t;

   vec_t vecs[$];
   exp_t ex_q[$], mem_q[$], wb_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic av(input logic r, input logic v, input logic [6:0] op,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic redir, input logic st, input logic il, input logic is,
                     input logic [12:0] ctrl, input logic [4:0] erd);
      vec_t x;
      x.rst = r; x.v = v; x.op = op; x.rs1 = rs1; x.rs2 = rs2; x.rd = rd;
      x.redir = redir; x.st = st; x.il = il; x.is = is; x.ctrl = ctrl; x.erd = erd;
      vecs.push_back(x);
   endtask

   // Monitors: one per stage, popping whenever that stage presents a valid entry.
   always @(negedge clk) begin
      exp_t e;
      if (ex_valid === 1'b1) begin
         if (ex_q.size() == 0) check("ex_unexpected", 32'd1, 32'd0);
         else begin
            e = ex_q.pop_front();
            check("ex_bundle", {ex_branch, ex_jump, ex_jalr, ex_ula_op, ex_src1, ex_src2, ex_rd},
                  {e.ctrl[12:4], e.rd});
         end
      end else if (ex_valid === 1'b0) begin
         check("ex_idle_zero", {ex_branch, ex_jump, ex_jalr, ex_ula_op, ex_src1, ex_src2, ex_rd}, 32'd0);
      end
      if (mem_valid === 1'b1) begin
         if (mem_q.size() == 0) check("mem_unexpected", 32'd1, 32'd0);
         else begin
            e = mem_q.pop_front();
            check("mem_bundle", {mem_rd, mem_wr}, e.ctrl[3:2]);
         end
      end
      if (wb_valid === 1'b1) begin
         if (wb_q.size() == 0) check("wb_unexpected", 32'd1, 32'd0);
         else begin
            e = wb_q.pop_front();
            check("wb_bundle", {wb_reg_wr, wb_mux, wb_rd}, {e.ctrl[1:0], e.rd});
         end
      end
   end

   initial begin
      logic prev_rst;
      exp_t e;
      prev_rst = 1'b0;
      //  rst v  op    rs1 rs2 rd  redir st il is  ctrl     erd
      av(1, 1, R,    1,  2,  5,  0,    0, 0, 0, K_NONE,  0);
      av(1, 1, R,    1,  2,  5,  0,    0, 0, 0, K_NONE,  0);
      av(0, 1, R,    1,  2,  5,  0,    0, 0, 1, K_R,     5);
      av(0, 1, I,    1,  0,  5,  0,    0, 0, 1, K_I,     5);
      av(0, 1, LD,   1,  0,  5,  0,    0, 0, 1, K_LD,    5);
      av(0, 1, ST,   2,  3,  5,  0,    0, 0, 1, K_ST,    5);
      av(0, 1, BR,   1,  2,  5,  0,    0, 0, 1, K_BR,    5);
      av(0, 1, LUI,  0,  0,  5,  0,    0, 0, 1, K_LUI,   5);
      av(0, 1, AUI,  0,  0,  5,  0,    0, 0, 1, K_AUI,   5);
      av(0, 1, JAL,  0,  0,  5,  0,    0, 0, 1, K_JAL,   5);
      av(0, 1, JALR, 1,  0,  5,  0,    0, 0, 1, K_JALR,  5);
      av(0, 1, SYS,  1,  2,  5,  0,    0, 1, 1, K_NONE,  0);
      av(0, 0, R,    1,  2,  5,  0,    0, 0, 0, K_NONE,  0);
      // load-use on rs1: one stall cycle, then the add issues
      av(0, 1, LD,   1,  0,  5,  0,    0, 0, 1, K_LD,    5);
      av(0, 1, R,    5,  1,  6,  0,    1, 0, 0, K_NONE,  0);
      av(0, 1, R,    5,  1,  6,  0,    0, 0, 1, K_R,     6);
      // load to x0 never interlocks
      av(0, 1, LD,   1,  0,  0,  0,    0, 0, 1, K_LD_X0, 0);
      av(0, 1, R,    0,  1,  6,  0,    0, 0, 1, K_R,     6);
      // rs fields of lui/jal are not sources
      av(0, 1, LD,   1,  0,  5,  0,    0, 0, 1, K_LD,    5);
      av(0, 1, LUI,  5,  5,  5,  0,    0, 0, 1, K_LUI,   5);
      av(0, 1, LD,   1,  0,  5,  0,    0, 0, 1, K_LD,    5);
      av(0, 1, JAL,  5,  5,  5,  0,    0, 0, 1, K_JAL,   5);
      // load-use on rs2 of a store
      av(0, 1, LD,   1,  0,  5,  0,    0, 0, 1, K_LD,    5);
      av(0, 1, ST,   1,  5,  0,  0,    1, 0, 0, K_NONE,  0);
      av(0, 1, ST,   1,  5,  0,  0,    0, 0, 1, K_ST,    0);
      // redirect squashes ID, and wins over a pending load-use stall
      av(0, 1, R,    1,  2,  6,  1,    0, 0, 0, K_NONE,  0);
      av(0, 1, LD,   1,  0,  5,  0,    0, 0, 1, K_LD,    5);
      av(0, 1, R,    5,  1,  6,  1,    0, 0, 0, K_NONE,  0);
      av(0, 1, R,    1,  2,  0,  0,    0, 0, 1, K_R_X0,  0);
      // mid-stream reset
      av(0, 1, I,    1,  0,  7,  0,    0, 0, 1, K_I,     7);
      av(1, 1, R,    1,  2,  5,  0,    0, 0, 0, K_NONE,  0);
      av(0, 1, R,    1,  2,  5,  0,    0, 0, 1, K_R,     5);
      for (int k = 0; k < 5; k++) av(0, 0, R, 0, 0, 0, 0, 0, 0, 0, K_NONE, 0);

      foreach (vecs[n]) begin
         @(posedge clk);
         #1;
         if (prev_rst) begin
            ex_q.delete(); mem_q.delete(); wb_q.delete();
            check("reset_state",
                  {ex_valid, ex_branch, ex_jump, ex_jalr, ex_ula_op, ex_src1, ex_src2, ex_rd,
                   mem_valid, mem_rd, mem_wr, wb_valid, wb_reg_wr, wb_mux, wb_rd}, 32'd0);
         end
         rst = vecs[n].rst;
         id_valid = vecs[n].v;
         id_opcode = vecs[n].op;
         id_rs1 = vecs[n].rs1;
         id_rs2 = vecs[n].rs2;
         id_rd = vecs[n].rd;
         ex_redirect = vecs[n].redir;
         #1;
         if (!vecs[n].rst) begin
            check("stall", {31'd0, stall}, {31'd0, vecs[n].st});
            check("id_illegal", {31'd0, id_illegal}, {31'd0, vecs[n].il});
            check("stall_disabled", {31'd0, ns_stall}, 32'd0);
         end
         if (vecs[n].is) begin
            e.ctrl = vecs[n].ctrl;
            e.rd = vecs[n].erd;
            ex_q.push_back(e); mem_q.push_back(e); wb_q.push_back(e);
         end
         prev_rst = vecs[n].rst;
      end
      @(negedge clk);
      #1;
      check("ex_q_drained", ex_q.size(), 32'd0);
      check("mem_q_drained", mem_q.size(), 32'd0);
      check("wb_q_drained", wb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
